// File: rtl/cdce_spi_pkg.sv
// ============================================================================
// Module : cdce_spi_pkg
// Brief  : Shared types and constants for the CDCE SPI transmitter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package cdce_spi_pkg;

    localparam int CDCE_WORD_W    = 32;
    localparam int LE_HIGH_HALVES = 2;
    localparam int FRAME_HALVES   = 68;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        LATCH = 3'd4
    } cdce_state_t;

    function automatic int half_cnt_width(input int half_period);
        return (half_period * LE_HIGH_HALVES <= 2) ? 1 : $clog2(half_period * LE_HIGH_HALVES);
    endfunction

    function automatic logic lead_bit(input logic [CDCE_WORD_W-1:0] word, input logic lsb_first);
        return lsb_first ? word[0] : word[CDCE_WORD_W-1];
    endfunction

endpackage

`default_nettype wire

// File: rtl/cdce_spi_half_tick.sv
// ============================================================================
// Module : cdce_spi_half_tick
// Brief  : Loadable down-counter; tick is high while the count sits at zero.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module cdce_spi_half_tick #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    output logic             tick
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_value;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign tick = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/cdce_spi_transmitter.sv
// ============================================================================
// Module : cdce_spi_transmitter
// Brief  : Shifts one 32-bit CDCE register word out as an SPI frame (68*H clk).
//          Optional MISO capture enabled by the CDCE_READBACK_EN macro.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module cdce_spi_transmitter
    import cdce_spi_pkg::*;
#(
    parameter int HALF_PERIOD = 4,
    parameter bit LSB_FIRST   = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start_transaction,
    input  logic [CDCE_WORD_W-1:0] cdce_command,
    output logic                   serial_ready,
    output logic                   spi_clk,
    output logic                   spi_mosi,
    output logic                   spi_le
`ifdef CDCE_READBACK_EN
    ,
    input  logic                   spi_miso,
    output logic [CDCE_WORD_W-1:0] read_data,
    output logic                   read_valid
`endif
);

    localparam int CNT_W = half_cnt_width(HALF_PERIOD);
    localparam logic [CNT_W-1:0] C_HALF_LOAD  = CNT_W'(HALF_PERIOD - 1);
    localparam logic [CNT_W-1:0] C_LATCH_LOAD = CNT_W'(LE_HIGH_HALVES * HALF_PERIOD - 1);

    cdce_state_t            r_state, w_state_nxt;
    logic [CDCE_WORD_W-1:0] r_shift, w_shifted;
    logic [4:0]             r_bit_cnt, w_bit_nxt;
    logic                   r_high, w_high_nxt;
    logic                   r_spi_clk, w_clk_nxt;
    logic                   r_spi_le, w_le_nxt;
    logic                   r_ready, w_rdy_nxt;
    logic                   r_mosi;
    logic                   w_tick, w_load, w_accept, w_advance, w_done;
    logic [CNT_W-1:0]       w_load_val;

    cdce_spi_half_tick #(.CNT_W(CNT_W)) u_half_tick (
        .clk        (clk),
        .reset      (reset),
        .load       (w_load),
        .load_value (w_load_val),
        .tick       (w_tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_load_val  = C_HALF_LOAD;
        w_clk_nxt   = r_spi_clk;
        w_le_nxt    = r_spi_le;
        w_rdy_nxt   = r_ready;
        w_high_nxt  = r_high;
        w_bit_nxt   = r_bit_cnt;
        w_accept    = 1'b0;
        w_advance   = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start_transaction) begin
                    w_state_nxt = SETUP;
                    w_load      = 1'b1;
                    w_accept    = 1'b1;
                    w_le_nxt    = 1'b0;
                    w_rdy_nxt   = 1'b0;
                    w_bit_nxt   = 5'd0;
                    w_high_nxt  = 1'b0;
                end
            end
            SETUP: begin
                if (w_tick) begin
                    w_state_nxt = SHIFT;
                    w_load      = 1'b1;
                    w_clk_nxt   = 1'b1;
                    w_high_nxt  = 1'b1;
                end
            end
            SHIFT: begin
                if (w_tick) begin
                    w_load = 1'b1;
                    if (r_high) begin
                        // Data moves on the falling edge; the last bit stays put through HOLD.
                        w_clk_nxt  = 1'b0;
                        w_high_nxt = 1'b0;
                        w_advance  = (r_bit_cnt != 5'd31);
                    end else if (r_bit_cnt == 5'd31) begin
                        w_state_nxt = HOLD;
                    end else begin
                        w_bit_nxt  = r_bit_cnt + 5'd1;
                        w_clk_nxt  = 1'b1;
                        w_high_nxt = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (w_tick) begin
                    w_state_nxt = LATCH;
                    w_load      = 1'b1;
                    w_load_val  = C_LATCH_LOAD;
                    w_le_nxt    = 1'b1;
                end
            end
            LATCH: begin
                if (w_tick) begin
                    w_state_nxt = IDLE;
                    w_rdy_nxt   = 1'b1;
                    w_done      = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_shifted = LSB_FIRST ? (r_shift >> 1) : (r_shift << 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift   <= '0;
            r_mosi    <= 1'b0;
            r_spi_clk <= 1'b0;
            r_spi_le  <= 1'b1;
            r_ready   <= 1'b1;
            r_high    <= 1'b0;
            r_bit_cnt <= 5'd0;
        end else begin
            r_spi_clk <= w_clk_nxt;
            r_spi_le  <= w_le_nxt;
            r_ready   <= w_rdy_nxt;
            r_high    <= w_high_nxt;
            r_bit_cnt <= w_bit_nxt;
            if (w_accept) begin
                r_shift <= cdce_command;
                r_mosi  <= lead_bit(cdce_command, LSB_FIRST);
            end else if (w_advance) begin
                r_shift <= w_shifted;
                r_mosi  <= lead_bit(w_shifted, LSB_FIRST);
            end
        end
    end

    assign serial_ready = r_ready;
    assign spi_clk      = r_spi_clk;
    assign spi_mosi     = r_mosi;
    assign spi_le       = r_spi_le;

`ifdef CDCE_READBACK_EN
    logic                   r_clk_q;
    logic [CDCE_WORD_W-1:0] r_rx;
    logic [CDCE_WORD_W-1:0] r_read_data;
    logic                   r_read_valid;

    // MISO is taken one clk after spi_clk goes high, well inside the high half.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clk_q      <= 1'b0;
            r_rx         <= '0;
            r_read_data  <= '0;
            r_read_valid <= 1'b0;
        end else begin
            r_clk_q      <= r_spi_clk;
            r_read_valid <= w_done;
            if (r_spi_clk && !r_clk_q) begin
                r_rx <= LSB_FIRST ? {spi_miso, r_rx[CDCE_WORD_W-1:1]}
                                  : {r_rx[CDCE_WORD_W-2:0], spi_miso};
            end
            if (w_done) begin
                r_read_data <= r_rx;
            end
        end
    end

    assign read_data  = r_read_data;
    assign read_valid = r_read_valid;
`endif

endmodule

`default_nettype wire
